// File: rtl/iohub_pkg.sv
// Purpose: shared iohub types and constants for the byte/word transmit and receive FSMs.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package iohub_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // Inter-byte timeout in clock cycles. Zero disables the timeout.
    localparam int RX_TIMEOUT_CYC = 50000;

    // State encodings. The transmit FSM uses the same encodings, so these
    // stay as plain localparams that both FSM enums are built from.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_LO = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;

    typedef enum logic [1:0] {
        RX_IDLE    = ST_IDLE,
        RX_WAIT_LO = ST_WAIT_LO,
        RX_WRITE   = ST_WRITE
    } rx_state_e;

    // The first byte of a pair is always the high byte.
    function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] hi,
                                                    input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Purpose: inter-byte timeout counter with clear, enable and terminal-count flag.
// Latency: tc_o is combinational from the registered count; clr/en act at the next edge.
// Backpressure: none; counts only while en_i is high.
//
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   clr_i         synchronous clear to zero (wins over en_i)
//   en_i          increment the count at the next edge
//   tc_o          count has reached TIMEOUT_CYC-1; held at 0 when TIMEOUT_CYC==0
module rx_timeout_timer
    import iohub_pkg::*;
#(
    parameter int TIMEOUT_CYC = RX_TIMEOUT_CYC,
    parameter int TO_W        = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic TO_ENABLED = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] TC_VAL = (TIMEOUT_CYC == 0) ? '0 : TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = TO_ENABLED && (cnt_q == TC_VAL);

endmodule

// File: rtl/receiving_fsm.sv
// Purpose: assembles UART byte pairs (high then low) into 16-bit words for the inbound FIFO.
// Latency: low byte strobed at edge N -> wr_en_o high during cycle N..N+1, FIFO samples at N+1.
// Backpressure: holds the word while fifo_full_i; a new high byte arriving meanwhile drops it (sticky overflow).
//
// Ports:
//   clk_i, rst_i     clock and asynchronous active-high reset
//   rx_byte_i        received byte, qualified by the one-cycle strobe rx_valid_i
//   is_receiving_i   enable; low discards a partial word and ignores rx
//   fifo_full_i      inbound FIFO full
//   wr_en_o, din_o   FIFO write strobe and data {high, low}
//   overflow_o       sticky: a held word was dropped because the FIFO stayed full
//   frame_err_o      sticky: a high byte was discarded by the inter-byte timeout
//   clr_err_i        synchronous clear of both sticky flags (a same-cycle set wins)
//   word_cnt_o       words committed to the FIFO, wraps 0xFFFF -> 0
module receiving_fsm
    import iohub_pkg::*;
#(
    parameter int TIMEOUT_CYC = RX_TIMEOUT_CYC,
    parameter int TO_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BYTE_W-1:0] rx_byte_i,
    input  logic              rx_valid_i,
    input  logic              is_receiving_i,
    input  logic              fifo_full_i,
    output logic              wr_en_o,
    output logic [WORD_W-1:0] din_o,
    output logic              overflow_o,
    output logic              frame_err_o,
    input  logic              clr_err_i,
    output logic [15:0]       word_cnt_o
);

    rx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              overflow_q, overflow_d;
    logic              frame_err_q, frame_err_d;
    logic [15:0]       word_cnt_q, word_cnt_d;

    logic wr_en;
    logic take_hi;
    logic ovf_set;
    logic ferr_set;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_tc;

    rx_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // The write strobe depends only on the registered state and the live full
    // flag, so the FIFO sees it one edge after the low byte was captured.
    assign wr_en = (state_q == RX_WRITE) && !fifo_full_i;

    // While disabled, rx strobes are ignored everywhere, including the
    // "next high byte" capture out of WRITE; the pending word still drains.
    assign take_hi = rx_valid_i && is_receiving_i;

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        din_d    = din_q;
        ovf_set  = 1'b0;
        ferr_set = 1'b0;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (take_hi) begin
                    hi_d    = rx_byte_i;
                    tmr_clr = 1'b1;
                    state_d = RX_WAIT_LO;
                end
            end

            RX_WAIT_LO: begin
                if (!is_receiving_i) begin
                    // Disabling abandons the partial word silently.
                    hi_d    = '0;
                    state_d = RX_IDLE;
                end else if (rx_valid_i) begin
                    din_d   = pack_word(hi_q, rx_byte_i);
                    state_d = RX_WRITE;
                end else if (tmr_tc) begin
                    hi_d     = '0;
                    ferr_set = 1'b1;
                    state_d  = RX_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            RX_WRITE: begin
                if (!fifo_full_i) begin
                    if (take_hi) begin
                        hi_d    = rx_byte_i;
                        tmr_clr = 1'b1;
                        state_d = RX_WAIT_LO;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else if (take_hi) begin
                    // The stream has moved on while the FIFO stayed full: the
                    // held word is lost and the new byte starts the next pair.
                    ovf_set = 1'b1;
                    hi_d    = rx_byte_i;
                    tmr_clr = 1'b1;
                    state_d = RX_WAIT_LO;
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // Set has priority over clear so an event in the clearing cycle is not lost.
        overflow_d  = ovf_set  | (overflow_q  & ~clr_err_i);
        frame_err_d = ferr_set | (frame_err_q & ~clr_err_i);

        word_cnt_d = wr_en ? (word_cnt_q + 16'd1) : word_cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RX_IDLE;
            hi_q        <= '0;
            din_q       <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            din_q       <= din_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign wr_en_o     = wr_en;
    assign din_o       = din_q;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
    assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_receiving_fsm.sv
// Purpose: scoreboard bench for receiving_fsm: directed byte streams, expected writes queued at issue time.
// Latency: a queued word must appear on wr_en_o within a bounded number of cycles.
// Backpressure: exercises fifo_full_i hold and overflow-drop paths.
module tb_receiving_fsm;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_byte_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        is_receiving_i = 1'b1;
    logic        fifo_full_i = 1'b0;
    logic        clr_err_i = 1'b0;
    logic        wr_en_o;
    logic [15:0] din_o;
    logic        overflow_o;
    logic        frame_err_o;
    logic [15:0] word_cnt_o;

    int errors = 0;
    int checks = 0;

    // Each entry: {expected din_o, expected word_cnt_o before the write}.
    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt = '0;

    receiving_fsm #(
        .TIMEOUT_CYC (8),
        .TO_W        (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_byte_i      (rx_byte_i),
        .rx_valid_i     (rx_valid_i),
        .is_receiving_i (is_receiving_i),
        .fifo_full_i    (fifo_full_i),
        .wr_en_o        (wr_en_o),
        .din_o          (din_o),
        .overflow_o     (overflow_o),
        .frame_err_o    (frame_err_o),
        .clr_err_i      (clr_err_i),
        .word_cnt_o     (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every write the DUT presents must match the head of the queue.
    always @(negedge clk_i) begin
        if (!rst_i && wr_en_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: din_o=%h cnt=%h, no write expected", din_o, word_cnt_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({din_o, word_cnt_o} !== e) begin
                    errors++;
                    $display("FAIL write_word: got din=%h cnt=%h, expected din=%h cnt=%h",
                             din_o, word_cnt_o, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic expect_word(input logic [15:0] w);
        exp_q.push_back({w, exp_cnt});
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected writes never seen", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        chk("reset_outputs", {wr_en_o, overflow_o, frame_err_o, din_o, word_cnt_o}, '0);
        rst_i = 1'b0;
        tick();

        // Reset in the middle of WAIT_LO.
        strobe(8'h12);
        rst_i = 1'b1;
        #2;
        chk("reset_mid_wait_lo", {wr_en_o, overflow_o, frame_err_o, din_o, word_cnt_o}, '0);
        tick();
        rst_i = 1'b0;
        tick();
        expect_word(16'h3456);
        strobe(8'h34);
        strobe(8'h56);
        wait_drain("after_reset_pair");

        // Basic pair and exact latency.
        tick();
        expect_word(16'hA53C);
        strobe(8'hA5);
        strobe(8'h3C);
        chk("basic_wr_en_one_edge_after", {31'd0, wr_en_o}, 32'd1);
        chk("basic_din", {16'd0, din_o}, 32'h0000A53C);
        tick();
        chk("basic_single_write", {31'd0, wr_en_o}, 32'd0);
        chk("basic_word_cnt", {16'd0, word_cnt_o}, 32'd2);

        // Back-to-back stream.
        expect_word(16'h0102);
        expect_word(16'h0304);
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        strobe(8'h04);
        wait_drain("back_to_back");
        tick();
        chk("b2b_no_flags", {30'd0, overflow_o, frame_err_o}, 32'd0);
        chk("b2b_word_cnt", {16'd0, word_cnt_o}, 32'd4);

        // FIFO full holds the word.
        fifo_full_i = 1'b1;
        strobe(8'hDE);
        strobe(8'hAD);
        repeat (10) tick();
        chk("full_hold_din", {16'd0, din_o}, 32'h0000DEAD);
        chk("full_no_wr_en", {31'd0, wr_en_o}, 32'd0);
        expect_word(16'hDEAD);
        fifo_full_i = 1'b0;
        wait_drain("full_release");

        // New high byte while full: held word dropped.
        tick();
        fifo_full_i = 1'b1;
        strobe(8'hCA);
        strobe(8'hFE);
        repeat (3) tick();
        strobe(8'h11);
        fifo_full_i = 1'b0;
        chk("overflow_set", {31'd0, overflow_o}, 32'd1);
        expect_word(16'h1122);
        strobe(8'h22);
        wait_drain("after_overflow");
        chk("overflow_sticky", {31'd0, overflow_o}, 32'd1);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk("overflow_cleared", {31'd0, overflow_o}, 32'd0);

        // Inter-byte timeout (8 cycles).
        strobe(8'h77);
        repeat (7) tick();
        chk("timeout_not_early", {31'd0, frame_err_o}, 32'd0);
        tick();
        chk("timeout_frame_err", {31'd0, frame_err_o}, 32'd1);
        expect_word(16'h8899);
        strobe(8'h88);
        strobe(8'h99);
        wait_drain("after_timeout");
        chk("frame_err_sticky", {31'd0, frame_err_o}, 32'd1);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk("frame_err_cleared", {31'd0, frame_err_o}, 32'd0);

        // Clear coinciding with a new timeout: set wins.
        strobe(8'h66);
        repeat (7) tick();
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk("set_beats_clear", {31'd0, frame_err_o}, 32'd1);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;

        // Disable drops the partial word without a framing error.
        strobe(8'h55);
        is_receiving_i = 1'b0;
        tick();
        is_receiving_i = 1'b1;
        repeat (12) tick();
        chk("disable_no_frame_err", {31'd0, frame_err_o}, 32'd0);
        chk("disable_no_write", {16'd0, word_cnt_o}, {16'd0, exp_cnt});
        expect_word(16'h5758);
        strobe(8'h57);
        strobe(8'h58);
        wait_drain("after_disable");

        // Word counter wrap.
        tick();
        @(negedge clk_i);
        force dut.word_cnt_q = 16'hFFFF;
        #1;
        release dut.word_cnt_q;
        tick();
        chk("cnt_preload", {16'd0, word_cnt_o}, 32'h0000FFFF);
        exp_cnt = 16'hFFFF;
        expect_word(16'hABCD);
        strobe(8'hAB);
        strobe(8'hCD);
        wait_drain("wrap_write");
        tick();
        chk("cnt_wrap", {16'd0, word_cnt_o}, 32'd0);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
